// File: rtl/diffusion_pkg.sv
// Shared types for the diffusion array control path.
// Lap FSM encoding, PE count and lap-index width.
package diffusion_pkg;

  localparam int NUM_PE = 8;
  localparam int LAP_W  = 32;

  typedef logic [LAP_W-1:0] lap_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } lap_state_t;

endpackage

// File: rtl/done_collector.sv
// Sticky per-PE lap-done flags and barrier detect.
// Flags a PE that reports twice within one lap.
module done_collector
  import diffusion_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [NUM_PE-1:0] done_i,
  input  logic [NUM_PE-1:0] mask,
  output logic              barrier_met,
  output logic              dup_err
);

  logic [NUM_PE-1:0] sticky;
  logic [NUM_PE-1:0] hit;

  assign hit         = done_i & mask;
  assign barrier_met = ((sticky | hit) == mask);
  assign dup_err     = en && |(hit & sticky);

  // Accumulate masked done pulses while collecting; clear per lap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sticky <= '0;
    end else if (clr) begin
      sticky <= '0;
    end else if (en) begin
      sticky <= sticky | hit;
    end
  end

endmodule

// File: rtl/lap_barrier_octa.sv
// Lap sequencer and barrier for the 8-PE diffusion array.
// Launches laps, waits on all enabled PEs, steps l_step.
module lap_barrier_octa
  import diffusion_pkg::*;
#(
  parameter int              DATA_WIDTH = LAP_W,
  parameter longint unsigned MAX_STEPS  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_PE-1:0]     pe_mask,
  input  logic [NUM_PE-1:0]     done_i,
  output logic                  lap_start,
  output logic [DATA_WIDTH-1:0] l_step,
  output logic                  busy,
  output logic                  all_done,
  output logic                  err
);

  localparam logic [DATA_WIDTH-1:0] LAST_IDX =
    DATA_WIDTH'(MAX_STEPS - 1);

  lap_state_t        state_q;
  lap_state_t        state_d;
  logic [NUM_PE-1:0] mask_q;
  logic              accept;
  logic              zero_start;
  logic              last;
  logic              barrier_met;
  logic              dup_err;
  logic              stray;

  assign last  = (l_step == LAST_IDX);
  assign stray = |(done_i & mask_q) && (state_q != S_WAIT);

  assign lap_start = (state_q == S_LAUNCH);
  assign all_done  = (state_q == S_FINISH);
  assign busy      = (state_q == S_LAUNCH)
                  || (state_q == S_WAIT)
                  || (state_q == S_ADVANCE);

  done_collector u_coll (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_q == S_LAUNCH),
    .en          (state_q == S_WAIT),
    .done_i      (done_i),
    .mask        (mask_q),
    .barrier_met (barrier_met),
    .dup_err     (dup_err)
  );

  // Next-state decode and start acceptance.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    zero_start = 1'b0;
    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          if (|pe_mask) begin
            accept  = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT:    if (barrier_met) state_d = S_ADVANCE;
      S_ADVANCE: state_d = last ? S_FINISH : S_LAUNCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, mask capture, lap index and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      l_step  <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mask_q <= pe_mask;
        l_step <= '0;
        err    <= 1'b0;
      end else begin
        if (state_q == S_ADVANCE && !last)
          l_step <= l_step + DATA_WIDTH'(1);
        if (zero_start || dup_err || stray)
          err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/lap_barrier_octa.md
Name: lap_barrier_octa

Overview:
- Lap sequencer and barrier for the 8-PE diffusion array.
- Issues a one-cycle lap_start to all PEs and collects each PE's lap-done pulse into sticky flags.
- When every enabled PE has reported, advances the lap counter l_step and launches the next lap, until MAX_STEPS laps are complete.
- Sits between the PS control registers and the PE array. It produces the per-lap step index that the diffusion datapath consumes.

Parameters:
- DATA_WIDTH, 32, width of l_step.
- MAX_STEPS, 7, number of laps per run; legal range 1 to 2^DATA_WIDTH-1.
- NUM_PE, 8, number of PEs; fixed at 8 for this block.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  PS run request, level or pulse; sampled only in IDLE and FINISH.
- pe_mask  in  8  enabled PEs; captured on an accepted start.
- done_i  in  8  per-PE lap-done pulse, one cycle per PE per lap.
- lap_start  out  1  one-cycle pulse telling the PEs to begin a lap.
- l_step  out  DATA_WIDTH  index of the current lap, starting at 0.
- busy  out  1  high from an accepted start until FINISH.
- all_done  out  1  high while in FINISH.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - l_step=0, sticky=0, mask_q=0.
  - lap_start=0, busy=0, all_done=0, err=0.
- States: IDLE, LAUNCH, WAIT, ADVANCE, FINISH. All outputs are registered or decoded from state.
- IDLE:
  - start=1 with pe_mask!=0: capture mask_q=pe_mask, set l_step=0, clear err, go to LAUNCH.
  - start=1 with pe_mask==0: set err=1 and stay in IDLE.
- LAUNCH:
  - lap_start=1 for exactly this cycle.
  - sticky cleared; go to WAIT.
- WAIT:
  - Each cycle: sticky <= sticky | (done_i & mask_q).
  - Barrier met when (sticky | (done_i & mask_q)) == mask_q. Go to ADVANCE on that edge.
- ADVANCE:
  - If l_step+1 == MAX_STEPS: go to FINISH and leave l_step unchanged (last lap index = MAX_STEPS-1).
  - Otherwise: l_step <= l_step+1 and go to LAUNCH.
- Latency: the final done_i arrives in cycle N. ADVANCE is cycle N+1. The next lap_start and the new l_step both appear in cycle N+2.
- FINISH:
  - all_done=1, busy=0, l_step holds MAX_STEPS-1.
  - start=1 restarts exactly as from IDLE, including mask capture and clearing err.
- busy=1 in LAUNCH, WAIT and ADVANCE.
- Error cases (err set sticky; no other effect):
  - done_i bit within mask_q asserted while its sticky bit is already set in WAIT.
  - done_i bit within mask_q asserted in LAUNCH, ADVANCE, IDLE or FINISH; the pulse is ignored.
- Unmasked done_i bits are always ignored and never raise err.
- pe_mask and start changes while busy are ignored.
- Several PEs finishing in the same cycle is legal and all are recorded.
- MAX_STEPS=1: after the first barrier, go straight from ADVANCE to FINISH with l_step=0.
- rst=0 mid-run: next state is IDLE with all outputs at their reset values; any in-flight lap is abandoned.
- l_step never wraps; it is bounded by MAX_STEPS-1.

Decomposition:
- Shared package (diffusion_pkg):
  - state enum encoding.
  - NUM_PE=8 constant.
  - lap-index width typedef, reused by the datapath.
- One sub-module, done_collector: 8-bit sticky OR register with a clear input, mask input, barrier_met output and dup_err output. The FSM stays in the top module.

Test Plan:
- Basic run: mask=0xFF, start; all 8 PEs pulse done_i 5 cycles after each lap_start. Expect 7 lap_start pulses, l_step stepping 0→6, all_done after the 7th barrier, and lap_start exactly 2 cycles after the last done each lap.
- Staggered and simultaneous done: PEs 0–3 pulse together, PEs 4–7 pulse singly over 4 later cycles. Expect no advance until PE 7's pulse, then ADVANCE next cycle.
- Partial mask: mask=0x05, only PEs 0 and 2 pulse and other done_i bits toggle randomly. Expect normal advance and err=0.
- Errors:
  - PE 3 pulses twice in one lap: err=1, but the lap still completes.
  - done_i pulse in FINISH: err=1.
  - start with mask=0: err=1 and the block stays in IDLE.
- Reset mid-WAIT at l_step=3: next cycle shows state IDLE, l_step=0, busy=0, err=0. A fresh start then runs to completion.
- Restart from FINISH: start again with mask=0x80. Expect err cleared, l_step=0, lap_start in the next cycle, and 7 laps completed.
